sub_serial: RTL and testbench



---
 rtl/sub_serial.sv | 137 +++++++++++++
 tb/tb_sub_serial.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one full-subtractor cell per clock.
// Define SUB_SERIAL_OVF_EN to add the signed-overflow output ovf.
module sub_serial #(
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             b_out_q, b_out_d;
  logic             d_bit;
  logic             br_next;

`ifdef SUB_SERIAL_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // The single full-subtractor cell.
  assign d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    b_out_d = b_out_q;
`ifdef SUB_SERIAL_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        // DONE also accepts a new start so back-to-back operations run at one per WIDTH+1 cycles.
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = b_in;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = SHIFT;
`ifdef SUB_SERIAL_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          b_out_d = br_next;
`ifdef SUB_SERIAL_OVF_EN
          // d_bit is the final result MSB on the last shift.
          ovf_d = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      b_out_q <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      b_out_q <= b_out_d;
`ifdef SUB_SERIAL_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign b_out = b_out_q;
`ifdef SUB_SERIAL_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial at WIDTH 2, 4 and 8 (three instances sharing clk/rst).
module tb_sub_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       st2 = 0, bi2 = 0, busy2, done2, bo2;
  logic [1:0] a2 = 0, b2 = 0, diff2;
  logic       st4 = 0, bi4 = 0, busy4, done4, bo4;
  logic [3:0] a4 = 0, b4 = 0, diff4;
  logic       st8 = 0, bi8 = 0, busy8, done8, bo8;
  logic [7:0] a8 = 0, b8 = 0, diff8;
`ifdef SUB_SERIAL_OVF_EN
  logic ov2, ov4, ov8;
`endif

  sub_serial #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .b_in(bi2),
    .busy(busy2), .done(done2), .diff(diff2), .b_out(bo2)
`ifdef SUB_SERIAL_OVF_EN
    , .ovf(ov2)
`endif
  );
  sub_serial #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .b_in(bi4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(bo4)
`ifdef SUB_SERIAL_OVF_EN
    , .ovf(ov4)
`endif
  );
  sub_serial #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .b_in(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .b_out(bo8)
`ifdef SUB_SERIAL_OVF_EN
    , .ovf(ov8)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          w;
    logic [31:0] a, b;
    logic        bin;
    logic [31:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic bi);
    case (w)
      2: begin st2 = s; a2 = av[1:0]; b2 = bv[1:0]; bi2 = bi; end
      4: begin st4 = s; a4 = av[3:0]; b4 = bv[3:0]; bi4 = bi; end
      default: begin st8 = s; a8 = av[7:0]; b8 = bv[7:0]; bi8 = bi; end
    endcase
  endtask

  function automatic logic done_of(input int w);
    case (w)
      2: return done2;
      4: return done4;
      default: return done8;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      2: return busy2;
      4: return busy4;
      default: return busy8;
    endcase
  endfunction

  task automatic sample(input int w, output logic [31:0] dv, output logic bo, output logic ov);
    ov = 1'b0;
    case (w)
      2: begin dv = 32'(diff2); bo = bo2;
`ifdef SUB_SERIAL_OVF_EN
        ov = ov2;
`endif
      end
      4: begin dv = 32'(diff4); bo = bo4;
`ifdef SUB_SERIAL_OVF_EN
        ov = ov4;
`endif
      end
      default: begin dv = 32'(diff8); bo = bo8;
`ifdef SUB_SERIAL_OVF_EN
        ov = ov8;
`endif
      end
    endcase
  endtask

  // Reference arithmetic: modulo difference, borrow, signed overflow.
  task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv, input logic bi,
                       output logic [31:0] dv, output logic bo, output logic ov);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    dv   = (av - bv - 32'(bi)) & mask;
    bo   = ({1'b0, av} < ({1'b0, bv} + 33'(bi)));
    ov   = (av[w-1] != bv[w-1]) && (dv[w-1] != av[w-1]);
  endtask

  // Pulse start, wait for done; k counts negedges after the start negedge.
  // done between edges N+W and N+W+1 means k == W+1.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic bi,
                        output logic [31:0] dv, output logic bo, output logic ov, output int k);
    @(negedge clk);
    drive(w, 1'b1, av, bv, bi);
    @(negedge clk);
    drive(w, 1'b0, av, bv, bi);
    k = 1;
    while (!done_of(w) && k < 40) begin
      @(negedge clk);
      k++;
    end
    sample(w, dv, bo, ov);
  endtask

  task automatic check_op(input string tag, input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic bi, input logic [31:0] ed, input logic eb, input logic eo);
    logic [31:0] dv;
    logic bo, ov;
    int k;
    run_op(w, av, bv, bi, dv, bo, ov, k);
    chk({tag, "_lat"}, 32'(k), 32'(w + 1));
    chk({tag, "_diff"}, dv, ed);
    chk({tag, "_bout"}, 32'(bo), 32'(eb));
`ifdef SUB_SERIAL_OVF_EN
    chk({tag, "_ovf"}, 32'(ov), 32'(eo));
`else
    if (eo === 1'bx) chk({tag, "_ovf"}, 32'(ov), 32'(eo));
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_of(w)), 32'd0);
    chk({tag, "_idle"}, 32'(busy_of(w)), 32'd0);
    $display("op w=%0d a=0x%0h b=0x%0h bin=%0d -> diff=0x%0h b_out=%0d", w, av, bv, bi, dv, bo);
  endtask

  initial begin
    vec_t vecs[9];
    logic [31:0] dv, ed;
    logic bo, eb, ov, eo;
    int k;

    vecs[0] = '{2, 3, 1, 0, 2, 0, 0};
    vecs[1] = '{2, 1, 2, 0, 3, 1, 1};
    vecs[2] = '{2, 0, 0, 1, 3, 1, 0};
    vecs[3] = '{2, 3, 3, 0, 0, 0, 0};
    vecs[4] = '{8, 'h80, 'h01, 0, 'h7F, 0, 1};
    vecs[5] = '{8, 'h10, 'h01, 0, 'h0F, 0, 0};
    vecs[6] = '{8, 'h0A, 'h03, 0, 'h07, 0, 0};
    vecs[7] = '{8, 'h7F, 'hFF, 0, 'h80, 1, 1};
    vecs[8] = '{8, 'h00, 'h00, 1, 'hFF, 1, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_diff", 32'(diff8), 0);
    chk("rst_bout", 32'(bo8), 0);
    rst = 1'b0;

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].bin,
               vecs[i].exp_diff, vecs[i].exp_bout, vecs[i].exp_ovf);

    // Exhaustive WIDTH=2 sweep
    for (int x = 0; x < 32; x++) begin
      model(2, 32'(x[4:3]), 32'(x[2:1]), x[0], ed, eb, eo);
      check_op($sformatf("sweep%0d", x), 2, 32'(x[4:3]), 32'(x[2:1]), x[0], ed, eb, eo);
    end

    // Start while busy is ignored
    @(negedge clk);
    drive(8, 1'b1, 'h00, 'h01, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 'h00, 'h01, 1'b0);
    repeat (2) @(negedge clk);
    drive(8, 1'b1, 'h55, 'h01, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 'h55, 'h01, 1'b0);
    k = 4;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ign_lat", 32'(k), 32'd9);
    chk("ign_diff", 32'(diff8), 32'hFF);
    chk("ign_bout", 32'(bo8), 32'd1);
    $display("op w=8 a=0x0 b=0x1 (second start ignored) -> diff=0x%0h b_out=%0d", diff8, bo8);
    @(negedge clk);
    chk("ign_idle", 32'(busy8), 32'd0);

    // Asynchronous reset four shifts into an operation
    @(negedge clk);
    drive(8, 1'b1, 'hFF, 'h00, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 'hFF, 'h00, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_rst_diff", 32'(diff8), 32'hF0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy8), 0);
    chk("arst_done", 32'(done8), 0);
    chk("arst_diff", 32'(diff8), 0);
    chk("arst_bout", 32'(bo8), 0);
    $display("async reset mid-SHIFT -> busy=%0d diff=0x%0h b_out=%0d", busy8, diff8, bo8);
    @(negedge clk);
    rst = 1'b0;
    check_op("post_rst", 8, 'h0A, 'h03, 1'b0, 'h07, 1'b0, 1'b0);

    // Start held high on WIDTH=4: results every 5 cycles, new operands each cycle
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      chk($sformatf("held_done%0d", j), 32'(done4), 32'((j >= 5) && (j % 5 == 0)));
      if (j >= 5 && j % 5 == 0) begin
        model(4, 32'(((j - 5) * 7 + 3) % 16), 32'(((j - 5) * 5 + 1) % 16), 1'((j - 5) & 1), ed, eb, eo);
        chk($sformatf("held_diff%0d", j), 32'(diff4), ed);
        chk($sformatf("held_bout%0d", j), 32'(bo4), 32'(eb));
        $display("held-start result at cycle %0d -> diff=0x%0h b_out=%0d", j, diff4, bo4);
      end
      drive(4, 1'b1, 32'((j * 7 + 3) % 16), 32'((j * 5 + 1) % 16), 1'(j & 1));
    end
    @(negedge clk);
    drive(4, 1'b0, 0, 0, 1'b0);
    repeat (8) @(negedge clk);
    chk("held_idle", 32'(busy4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
